// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared types and elaboration helpers for the iterative
//               unsigned multiplier (state encoding, iteration count,
//               counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mul_pkg;

    // Controller states; encoding fixed so the state register is 2 bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_mul_state_t;

    // Number of iterations needed to retire every multiplier bit.
    function automatic int seq_mul_steps(input int word_width, input int bits_per_cycle);
        return word_width / bits_per_cycle;
    endfunction

    // Counter must be able to hold the value N itself, hence N+1 codes.
    function automatic int seq_mul_cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_step.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_step
// Description : Combinational single-iteration datapath of the iterative
//               multiplier. Adds mcand * b_chunk to the accumulator as a sum
//               of shifted partial products and advances the multiplicand.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_step
    import seq_mul_pkg::*;
#(
    parameter int WORD_WIDTH     = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WORD_WIDTH-1:0]   i_acc,
    input  logic [2*WORD_WIDTH-1:0]   i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_b_chunk,
    output logic [2*WORD_WIDTH-1:0]   o_acc_next,
    output logic [2*WORD_WIDTH-1:0]   o_mcand_next
);

    localparam int c_pw = 2 * WORD_WIDTH;

    logic [c_pw-1:0] w_pp [BITS_PER_CYCLE];
    logic [c_pw-1:0] w_sum;

    // One partial product per multiplier bit in the chunk: mcand shifted by
    // the bit position, gated by that bit.
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
        assign w_pp[gi] = i_b_chunk[gi] ? (i_mcand << gi) : '0;
    end

    // Accumulate the partial products onto the running sum; the full product
    // fits in 2*WORD_WIDTH bits so no carry out is lost.
    always_comb begin
        w_sum = i_acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_sum = w_sum + w_pp[i];
        end
    end

    assign o_acc_next   = w_sum;
    assign o_mcand_next = i_mcand << BITS_PER_CYCLE;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative unsigned multiplier with valid/ready handshakes.
//               Retires BITS_PER_CYCLE multiplier bits per clock and presents
//               the exact 2*WORD_WIDTH-bit product after N = WORD_WIDTH /
//               BITS_PER_CYCLE cycles.
//               Optional build macro SEQ_MUL_EARLY_TERM_EN: finish as soon as
//               the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WORD_WIDTH     = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_WIDTH-1:0]   a,
    input  logic [WORD_WIDTH-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WORD_WIDTH-1:0] product,
    output logic                    busy
);

    localparam int c_pw    = 2 * WORD_WIDTH;
    localparam int c_steps = seq_mul_steps(WORD_WIDTH, BITS_PER_CYCLE);
    localparam int c_cnt_w = seq_mul_cnt_width(c_steps);

    seq_mul_state_t r_state;
    seq_mul_state_t w_state_nxt;

    logic [c_pw-1:0]       r_acc;
    logic [c_pw-1:0]       r_mcand;
    logic [WORD_WIDTH-1:0] r_b;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [c_pw-1:0]       w_acc_nxt;
    logic [c_pw-1:0]       w_mcand_nxt;
    logic [WORD_WIDTH-1:0] w_b_shift;
    logic                  w_accept;
    logic                  w_last;

    seq_mul_step #(
        .WORD_WIDTH     (WORD_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_acc        (r_acc),
        .i_mcand      (r_mcand),
        .i_b_chunk    (r_b[BITS_PER_CYCLE-1:0]),
        .o_acc_next   (w_acc_nxt),
        .o_mcand_next (w_mcand_nxt)
    );

    assign w_b_shift = r_b >> BITS_PER_CYCLE;

`ifdef SEQ_MUL_EARLY_TERM_EN
    // Stop on the final count or once no multiplier bits remain after this step.
    assign w_last = (r_cnt == c_cnt_w'(1)) || (w_b_shift == '0);
`else
    // Fixed latency: always run the full N iterations.
    assign w_last = (r_cnt == c_cnt_w'(1));
`endif

    // Only IDLE accepts operands; reset masks readiness immediately.
    assign in_ready = (r_state == IDLE) && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and operand acceptance strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then one shift-add step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_acc   <= '0;
            r_mcand <= {{WORD_WIDTH{1'b0}}, a};
            r_b     <= b;
            r_cnt   <= c_cnt_w'(c_steps);
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_nxt;
            r_mcand <= w_mcand_nxt;
            r_b     <= w_b_shift;
            r_cnt   <= r_cnt - c_cnt_w'(1);
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier (k=1 and k=4 builds)
//               and the standalone seq_mul_step datapath. Expected products
//               and latencies come from plain arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    logic              clk;
    logic              rst;
    logic [1:0]        in_valid_s;
    logic [1:0]        in_ready_s;
    logic [1:0][15:0]  a_s;
    logic [1:0][15:0]  b_s;
    logic [1:0]        out_valid_s;
    logic [1:0]        out_ready_s;
    logic [1:0][31:0]  product_s;
    logic [1:0]        busy_s;

    logic [31:0] st_acc, st_mcand, st_acc_nxt, st_mcand_nxt;
    logic [3:0]  st_chunk;

    int n_cmp = 0;
    int n_bad = 0;

    seq_multiplier #(.WORD_WIDTH(16), .BITS_PER_CYCLE(1)) u_dut_k1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .product(product_s[0]), .busy(busy_s[0])
    );

    seq_multiplier #(.WORD_WIDTH(16), .BITS_PER_CYCLE(4)) u_dut_k4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .product(product_s[1]), .busy(busy_s[1])
    );

    seq_mul_step #(.WORD_WIDTH(16), .BITS_PER_CYCLE(4)) u_step (
        .i_acc(st_acc), .i_mcand(st_mcand), .i_b_chunk(st_chunk),
        .o_acc_next(st_acc_nxt), .o_mcand_next(st_mcand_nxt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
        $fatal(1);
    end

    // Cycles from handshake to out_valid, from the operand value alone.
    function automatic int exp_lat(input int k, input logic [15:0] y);
        int bl;
        bl = 0;
        for (int i = 0; i < 16; i++) if (y[i]) bl = i + 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
        return (bl == 0) ? 1 : (bl + k - 1) / k;
`else
        return (bl >= 0) ? 16 / k : 0;
`endif
    endfunction

    function automatic int kof(input int sel);
        return (sel == 1) ? 4 : 1;
    endfunction

    // Present operands, wait for the handshake, then count cycles to out_valid.
    task automatic do_op(input int sel, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output logic [31:0] p);
        int guard;
        @(negedge clk);
        a_s[sel] = x;
        b_s[sel] = y;
        in_valid_s[sel] = 1'b1;
        guard = 0;
        while (!in_ready_s[sel] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid_s[sel] = 1'b0;
        lat = 0;
        while (!out_valid_s[sel] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        p = product_s[sel];
    endtask

    task automatic consume(input int sel);
        out_ready_s[sel] = 1'b1;
        @(negedge clk);
        out_ready_s[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid_s = 2'b11;
        a_s[0] = 16'h1234; b_s[0] = 16'h5678;
        a_s[1] = 16'h1234; b_s[1] = 16'h5678;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (in_ready_s[s] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b need 0", s, in_ready_s[s]); end
            n_cmp++;
            if (out_valid_s[s] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %b need 0", s, out_valid_s[s]); end
            n_cmp++;
            if (product_s[s] !== 32'h0) begin n_bad++; $display("FAIL reset_product[%0d]: got %h need 0", s, product_s[s]); end
        end
        rst = 1'b0;
        in_valid_s = 2'b00;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (in_ready_s[s] !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready[%0d]: got %b need 1", s, in_ready_s[s]); end
            n_cmp++;
            if (busy_s[s] !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy[%0d]: got %b need 0", s, busy_s[s]); end
        end
    endtask

    task automatic test_basic;
        int lat;
        logic [31:0] p;
        do_op(0, 16'h00FF, 16'h0101, lat, p);
        n_cmp++;
        if (lat != exp_lat(1, 16'h0101)) begin n_bad++; $display("FAIL basic_latency: got %0d need %0d", lat, exp_lat(1, 16'h0101)); end
        n_cmp++;
        if (p !== 32'h0000FFFF) begin n_bad++; $display("FAIL basic_product: got %h need 0000ffff", p); end
        n_cmp++;
        if (busy_s[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy_done: got %b need 1", busy_s[0]); end
        consume(0);
        n_cmp++;
        if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_after_consume: got ov=%b ir=%b busy=%b need 0 1 0", out_valid_s[0], in_ready_s[0], busy_s[0]);
        end
    endtask

    task automatic test_extremes;
        int lat;
        logic [31:0] p;
        do_op(1, 16'hFFFF, 16'hFFFF, lat, p);
        n_cmp++;
        if (p !== 32'hFFFE0001) begin n_bad++; $display("FAIL extreme_max_product: got %h need fffe0001", p); end
        n_cmp++;
        if (lat != exp_lat(4, 16'hFFFF)) begin n_bad++; $display("FAIL extreme_max_latency: got %0d need %0d", lat, exp_lat(4, 16'hFFFF)); end
        consume(1);
        do_op(1, 16'h0000, 16'h1234, lat, p);
        n_cmp++;
        if (p !== 32'h0) begin n_bad++; $display("FAIL extreme_zero_product: got %h need 0", p); end
        n_cmp++;
        if (lat != exp_lat(4, 16'h1234)) begin n_bad++; $display("FAIL extreme_zero_latency: got %0d need %0d", lat, exp_lat(4, 16'h1234)); end
        consume(1);
    endtask

    task automatic test_backpressure;
        int lat;
        logic [31:0] p;
        logic [15:0] x, y;
        x = 16'($urandom);
        y = 16'($urandom);
        do_op(0, x, y, lat, p);
        n_cmp++;
        if (p !== 32'(x) * 32'(y)) begin n_bad++; $display("FAIL bp_product: got %h need %h", p, 32'(x) * 32'(y)); end
        for (int i = 0; i < 5; i++) begin
            in_valid_s[0] = 1'b1;
            a_s[0] = ~x;
            b_s[0] = ~y;
            @(negedge clk);
            n_cmp++;
            if (product_s[0] !== p || in_ready_s[0] !== 1'b0 || out_valid_s[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got prod=%h ir=%b ov=%b need prod=%h ir=0 ov=1", i, product_s[0], in_ready_s[0], out_valid_s[0], p);
            end
        end
        in_valid_s[0] = 1'b0;
        consume(0);
        n_cmp++;
        if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: got ov=%b ir=%b busy=%b need 0 1 0", out_valid_s[0], in_ready_s[0], busy_s[0]);
        end
    endtask

    task automatic test_reset_midop;
        int lat;
        logic [31:0] p;
        bit seen;
        @(negedge clk);
        a_s[0] = 16'd7;
        b_s[0] = 16'd9;
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid_s[0] === 1'b1) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid_s[0] !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL midop_abandon: got out_valid=1 need 0"); end
        do_op(0, 16'd3, 16'd5, lat, p);
        n_cmp++;
        if (p !== 32'd15) begin n_bad++; $display("FAIL midop_next_product: got %0d need 15", p); end
        n_cmp++;
        if (lat != exp_lat(1, 16'd5)) begin n_bad++; $display("FAIL midop_next_latency: got %0d need %0d", lat, exp_lat(1, 16'd5)); end
        consume(0);
    endtask

    task automatic test_early_term;
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        int lat;
        logic [31:0] p;
        xs[0] = 16'h5A5A; ys[0] = 16'h0000;
        xs[1] = 16'hABCD; ys[1] = 16'h0001;
        xs[2] = 16'($urandom); ys[2] = 16'h0080;
        for (int i = 0; i < 3; i++) begin
            do_op(0, xs[i], ys[i], lat, p);
            n_cmp++;
            if (lat != exp_lat(1, ys[i])) begin n_bad++; $display("FAIL early_latency[%0d]: got %0d need %0d", i, lat, exp_lat(1, ys[i])); end
            n_cmp++;
            if (p !== 32'(xs[i]) * 32'(ys[i])) begin n_bad++; $display("FAIL early_product[%0d]: got %h need %h", i, p, 32'(xs[i]) * 32'(ys[i])); end
            consume(0);
        end
    endtask

    task automatic test_random;
        int lat, sel, d;
        logic [31:0] p;
        logic [15:0] x, y;
        for (int i = 0; i < 24; i++) begin
            sel = i % 2;
            x = 16'($urandom);
            y = (i % 5 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            do_op(sel, x, y, lat, p);
            n_cmp++;
            if (p !== 32'(x) * 32'(y)) begin n_bad++; $display("FAIL rand_product[%0d]: got %h need %h", i, p, 32'(x) * 32'(y)); end
            n_cmp++;
            if (lat != exp_lat(kof(sel), y)) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d need %0d", i, lat, exp_lat(kof(sel), y)); end
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            n_cmp++;
            if (product_s[sel] !== p || out_valid_s[sel] !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_stable[%0d]: got %h ov=%b need %h ov=1", i, product_s[sel], out_valid_s[sel], p);
            end
            consume(sel);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_back_to_back;
        int t_prev, t_now, guard, prev_lat;
        logic [15:0] x, y;
        out_ready_s[0] = 1'b1;
        t_prev = 0;
        prev_lat = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            a_s[0] = x;
            b_s[0] = y;
            in_valid_s[0] = 1'b1;
            guard = 0;
            while (!in_ready_s[0] && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            t_now = cyc;
            if (i > 0) begin
                n_cmp++;
                if (t_now - t_prev != prev_lat + 2) begin
                    n_bad++;
                    $display("FAIL b2b_interval[%0d]: got %0d need %0d", i, t_now - t_prev, prev_lat + 2);
                end
            end
            t_prev = t_now;
            prev_lat = exp_lat(1, y);
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!out_valid_s[0] && guard < 100);
            n_cmp++;
            if (product_s[0] !== 32'(x) * 32'(y)) begin
                n_bad++;
                $display("FAIL b2b_product[%0d]: got %h need %h", i, product_s[0], 32'(x) * 32'(y));
            end
        end
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        out_ready_s[0] = 1'b0;
    endtask

    task automatic test_step;
        logic [63:0] full;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            st_acc   = $urandom;
            st_mcand = $urandom;
            st_chunk = 4'($urandom);
            #1;
            full = 64'(st_acc) + 64'(st_mcand) * 64'(st_chunk);
            n_cmp++;
            if (st_acc_nxt !== full[31:0]) begin n_bad++; $display("FAIL step_acc[%0d]: got %h need %h", i, st_acc_nxt, full[31:0]); end
            n_cmp++;
            if (st_mcand_nxt !== {st_mcand[27:0], 4'h0}) begin n_bad++; $display("FAIL step_mcand[%0d]: got %h need %h", i, st_mcand_nxt, {st_mcand[27:0], 4'h0}); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid_s = 2'b00;
        out_ready_s = 2'b00;
        a_s = '0;
        b_s = '0;
        st_acc = '0;
        st_mcand = '0;
        st_chunk = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_reset_midop();
        test_early_term();
        test_random();
        test_back_to_back();
        test_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
